// File: rtl/dec_rate_ctrl.sv
// dec_rate_ctrl: run sequencer for one decimator stage (clock-enable gating, phase tracking, output flagging).
// Latency: dec_en is combinational from in_valid; out_valid trails its accepting sample by OUT_LAT cycles; done follows OUT_LAT drain cycles.
// Backpressure: none; in_valid is consumed every RUN cycle and ignored otherwise, start is dropped while busy.
module dec_rate_ctrl #(
    parameter int MAX_FACTOR = 16,
    parameter int FACTOR_W   = 5,
    parameter int CNT_W      = 16,
    parameter int OUT_LAT    = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [FACTOR_W-1:0] cfg_factor,
    input  logic [CNT_W-1:0]    cfg_num_samples,
    input  logic                in_valid,
    output logic                dec_en,
    output logic [FACTOR_W-1:0] phase,
    output logic                out_valid,
    output logic [CNT_W-1:0]    out_count,
    output logic                busy,
    output logic                done,
    output logic                cfg_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [FACTOR_W-1:0] MAX_F      = FACTOR_W'(MAX_FACTOR);
    // OUT_LAT is at most 4, so a 3-bit drain counter always suffices.
    localparam logic [2:0]          DRAIN_LAST = 3'(OUT_LAT - 1);

    // Run configuration captured at an accepted start; held for the whole run.
    typedef struct packed {
        logic [FACTOR_W-1:0] factor;
        logic [CNT_W-1:0]    num;
    } run_cfg_t;

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    run_cfg_t           cfg_q;
    logic [CNT_W-1:0]   in_cnt;
    logic [2:0]         drain_cnt;
    logic [OUT_LAT-1:0] vld_pipe;
    logic [OUT_LAT-1:0] vld_pipe_nxt;

    logic cfg_ok;
    logic start_ok;
    logic start_bad;
    logic last_phase;
    logic last_sample;
    logic drain_last;
    logic inject;

    // A start is only considered in IDLE, and abort in the same cycle wins over it.
    assign cfg_ok      = (cfg_factor != '0) && (cfg_factor <= MAX_F) && (cfg_num_samples != '0);
    assign start_ok    = start && (state == ST_IDLE) && !abort && cfg_ok;
    assign start_bad   = start && (state == ST_IDLE) && !abort && !cfg_ok;

    // Sample acceptance and frame bookkeeping.
    assign dec_en      = in_valid && (state == ST_RUN);
    assign last_phase  = (phase == (cfg_q.factor - FACTOR_W'(1)));
    assign last_sample = (in_cnt == (cfg_q.num - CNT_W'(1)));
    assign drain_last  = (drain_cnt == DRAIN_LAST);
    // Only a completed frame emits an output; trailing partial frames never inject.
    assign inject      = dec_en && last_phase;

    assign out_valid   = vld_pipe[OUT_LAT-1];
    assign busy        = (state != ST_IDLE);

    // Next-state selection; abort overrides every state.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start_ok) state_nxt = ST_RUN;
                ST_RUN:   if (dec_en && last_sample) state_nxt = ST_DRAIN;
                ST_DRAIN: if (drain_last) state_nxt = ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // Output-valid delay line models the decimator latency; abort and a fresh start flush it.
    always_comb begin
        vld_pipe_nxt = (vld_pipe << 1) | OUT_LAT'(inject);
        if (abort || start_ok) begin
            vld_pipe_nxt = '0;
        end
    end

    // State register and valid delay line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            vld_pipe <= '0;
        end else begin
            state    <= state_nxt;
            vld_pipe <= vld_pipe_nxt;
        end
    end

    // Latch the run configuration when a legal start is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_q <= '0;
        end else if (start_ok) begin
            cfg_q <= '{factor: cfg_factor, num: cfg_num_samples};
        end
    end

    // Input counter and decimation phase advance only on accepted samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_cnt <= '0;
            phase  <= '0;
        end else if (start_ok) begin
            in_cnt <= '0;
            phase  <= '0;
        end else if (abort) begin
            phase  <= '0;
        end else if (dec_en) begin
            in_cnt <= in_cnt + CNT_W'(1);
            phase  <= last_phase ? '0 : phase + FACTOR_W'(1);
        end
    end

    // out_count steps on the same edge that raises out_valid, so both are visible together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_count <= '0;
        end else if (start_ok) begin
            out_count <= '0;
        end else if (vld_pipe_nxt[OUT_LAT-1]) begin
            out_count <= out_count + CNT_W'(1);
        end
    end

    // Drain timer counts the cycles spent waiting for in-flight outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain_cnt <= '0;
        end else if (state == ST_DRAIN && !abort) begin
            drain_cnt <= drain_cnt + 3'd1;
        end else begin
            drain_cnt <= '0;
        end
    end

    // One-cycle status pulses: done on normal completion, cfg_err on a rejected start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            done    <= (state == ST_DRAIN) && drain_last && !abort;
            cfg_err <= start_bad;
        end
    end

endmodule

// File: tb/tb_dec_rate_ctrl.sv
// tb_dec_rate_ctrl: directed checks of dec_rate_ctrl at OUT_LAT=1 (u_lat1) and OUT_LAT=3 (u_lat3).
// Latency: both instances share stimulus; each scenario waits until both are idle before starting.
// Backpressure: not applicable; in_valid patterns are driven directly.
module tb_dec_rate_ctrl;
    localparam int FW = 5;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          in_valid = 1'b0;
    logic [FW-1:0] cfg_factor = '0;
    logic [CW-1:0] cfg_num_samples = '0;

    logic          a_dec_en, a_out_valid, a_busy, a_done, a_cfg_err;
    logic [FW-1:0] a_phase;
    logic [CW-1:0] a_out_count;
    logic          b_dec_en, b_out_valid, b_busy, b_done, b_cfg_err;
    logic [FW-1:0] b_phase;
    logic [CW-1:0] b_out_count;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    dec_rate_ctrl #(.MAX_FACTOR(16), .FACTOR_W(FW), .CNT_W(CW), .OUT_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_factor(cfg_factor), .cfg_num_samples(cfg_num_samples), .in_valid(in_valid),
        .dec_en(a_dec_en), .phase(a_phase), .out_valid(a_out_valid), .out_count(a_out_count),
        .busy(a_busy), .done(a_done), .cfg_err(a_cfg_err)
    );

    dec_rate_ctrl #(.MAX_FACTOR(16), .FACTOR_W(FW), .CNT_W(CW), .OUT_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_factor(cfg_factor), .cfg_num_samples(cfg_num_samples), .in_valid(in_valid),
        .dec_en(b_dec_en), .phase(b_phase), .out_valid(b_out_valid), .out_count(b_out_count),
        .busy(b_busy), .done(b_done), .cfg_err(b_cfg_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // One cycle: drive inputs just after the edge, then settle before checking.
    task automatic cyc(input logic iv, input logic st, input logic ab);
        @(posedge clk);
        #1;
        in_valid = iv;
        start    = st;
        abort    = ab;
        #1;
    endtask

    task automatic go(input int f, input int n);
        cfg_factor      = FW'(f);
        cfg_num_samples = CW'(n);
        cyc(1'b0, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // ---------------- reset ----------------
        rst = 1'b0;
        #1 rst = 1'b1;
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",   a_busy, 0);
        chk("rst_dec_en", a_dec_en, 0);
        chk("rst_phase",  a_phase, 0);
        chk("rst_count",  a_out_count, 0);
        chk("rst_ovld",   a_out_valid, 0);
        chk("rst_done",   a_done, 0);
        chk("rst_cfgerr", a_cfg_err, 0);
        chk("rst_busy3",  b_busy, 0);
        in_valid = 1'b0;
        rst = 1'b0;
        idle(2);

        // ---------------- F=4, N=16, continuous ----------------
        go(4, 16);
        chk("s1_start_busy", a_busy, 0);
        for (int j = 1; j <= 16; j++) begin
            cyc(1'b1, 1'b0, 1'b0);
            chk("s1_dec_en", a_dec_en, 1);
            chk("s1_phase",  a_phase, (j - 1) % 4);
            chk("s1_ovld",   a_out_valid, (j == 5 || j == 9 || j == 13) ? 1 : 0);
            chk("s1_count",  a_out_count, (j - 1) / 4);
            chk("s1_busy",   a_busy, 1);
        end
        cyc(1'b1, 1'b0, 1'b0);
        chk("s1_drain_dec_en", a_dec_en, 0);
        chk("s1_drain_busy",   a_busy, 1);
        chk("s1_drain_ovld",   a_out_valid, 1);
        chk("s1_drain_count",  a_out_count, 4);
        chk("s1_drain_done",   a_done, 0);
        chk("s1_drain_phase",  a_phase, 0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("s1_done",      a_done, 1);
        chk("s1_done_busy", a_busy, 0);
        chk("s1_done_ovld", a_out_valid, 0);
        chk("s1_done_cnt",  a_out_count, 4);
        cyc(1'b0, 1'b0, 1'b0);
        chk("s1_done_once", a_done, 0);
        chk("s1_hold_cnt",  a_out_count, 4);
        idle(4);

        // ---------------- F=3, N=10, toggling in_valid, start while busy ----------------
        go(3, 10);
        for (int t = 0; t <= 18; t++) begin
            if (t == 7) begin
                cfg_factor      = FW'(1);
                cfg_num_samples = CW'(2);
            end
            cyc((t % 2) == 0, t == 7, 1'b0);
            chk("s2_dec_en", a_dec_en, ((t % 2) == 0) ? 1 : 0);
            chk("s2_phase",  a_phase, ((t + 1) / 2) % 3);
            chk("s2_ovld",   a_out_valid, (t == 5 || t == 11 || t == 17) ? 1 : 0);
            chk("s2_count",  a_out_count, (t >= 5 ? 1 : 0) + (t >= 11 ? 1 : 0) + (t >= 17 ? 1 : 0));
            chk("s2_busy",   a_busy, 1);
            chk("s2_done",   a_done, 0);
            chk("s2_cfgerr", a_cfg_err, 0);
        end
        cyc(1'b1, 1'b0, 1'b0);
        chk("s2_drain_dec_en", a_dec_en, 0);
        chk("s2_drain_busy",   a_busy, 1);
        chk("s2_drain_ovld",   a_out_valid, 0);
        chk("s2_drain_count",  a_out_count, 3);
        chk("s2_drain_phase",  a_phase, 1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("s2_done",       a_done, 1);
        chk("s2_final_cnt",  a_out_count, 3);
        cyc(1'b0, 1'b0, 1'b0);
        chk("s2_done_once",  a_done, 0);
        idle(4);

        // ---------------- F=1, N=5 on OUT_LAT=3 ----------------
        go(1, 5);
        for (int c = 1; c <= 9; c++) begin
            cyc(c <= 8, 1'b0, 1'b0);
            chk("s3_dec_en", b_dec_en, (c <= 5) ? 1 : 0);
            chk("s3_ovld",   b_out_valid, (c >= 4 && c <= 8) ? 1 : 0);
            chk("s3_count",  b_out_count, (c < 4) ? 0 : ((c - 3 > 5) ? 5 : c - 3));
            chk("s3_busy",   b_busy, (c <= 8) ? 1 : 0);
            chk("s3_done",   b_done, (c == 9) ? 1 : 0);
            chk("s3_phase",  b_phase, 0);
        end
        idle(3);

        // ---------------- illegal configurations ----------------
        go(0, 5);
        chk("s4_f0_same_cycle", a_cfg_err, 0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("s4_f0_err",   a_cfg_err, 1);
        chk("s4_f0_err3",  b_cfg_err, 1);
        chk("s4_f0_busy",  a_busy, 0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("s4_f0_pulse", a_cfg_err, 0);
        chk("s4_f0_idle",  a_busy, 0);
        go(17, 5);
        cyc(1'b0, 1'b0, 1'b0);
        chk("s4_f17_err",   a_cfg_err, 1);
        chk("s4_f17_busy",  a_busy, 0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("s4_f17_pulse", a_cfg_err, 0);
        go(4, 0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("s4_n0_err",  a_cfg_err, 1);
        chk("s4_n0_busy", a_busy, 0);

        // F=MAX, N=1: legal, single sample, partial frame gives no output
        go(16, 1);
        cyc(1'b1, 1'b0, 1'b0);
        chk("s4_fmax_err",    a_cfg_err, 0);
        chk("s4_fmax_busy",   a_busy, 1);
        chk("s4_fmax_dec_en", a_dec_en, 1);
        cyc(1'b1, 1'b0, 1'b0);
        chk("s4_fmax_drain_en", a_dec_en, 0);
        chk("s4_fmax_ovld",     a_out_valid, 0);
        chk("s4_fmax_phase",    a_phase, 1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("s4_fmax_done",  a_done, 1);
        chk("s4_fmax_count", a_out_count, 0);
        idle(4);

        // ---------------- F=4, N=100, abort after 9 accepts ----------------
        go(4, 100);
        for (int c = 1; c <= 9; c++) begin
            cyc(1'b1, 1'b0, 1'b0);
            chk("s5_ovld",  a_out_valid, (c == 5 || c == 9) ? 1 : 0);
            chk("s5_count", a_out_count, (c >= 9) ? 2 : ((c >= 5) ? 1 : 0));
        end
        cyc(1'b0, 1'b0, 1'b1);
        chk("s5_abort_busy",   a_busy, 1);
        chk("s5_abort_count",  a_out_count, 2);
        chk("s5_abort_count3", b_out_count, 1);
        for (int c = 11; c <= 13; c++) begin
            cyc(1'b0, 1'b0, 1'b0);
            chk("s5_idle_busy",   a_busy, 0);
            chk("s5_no_done",     a_done, 0);
            chk("s5_phase_clr",   a_phase, 0);
            chk("s5_count_hold",  a_out_count, 2);
            chk("s5_flush_ovld3", b_out_valid, 0);
            chk("s5_flush_cnt3",  b_out_count, 1);
            chk("s5_no_done3",    b_done, 0);
        end
        go(2, 2);
        cyc(1'b1, 1'b0, 1'b0);
        chk("s5_restart_busy",  a_busy, 1);
        chk("s5_restart_count", a_out_count, 0);
        chk("s5_restart_phase", a_phase, 0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("s5_restart_phase1", a_phase, 1);
        chk("s5_restart_en",     a_dec_en, 1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("s5_restart_ovld",  a_out_valid, 1);
        chk("s5_restart_cnt1",  a_out_count, 1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("s5_restart_done",  a_done, 1);
        idle(4);

        // ---------------- asynchronous reset mid-run, F=2 ----------------
        go(2, 10);
        for (int c = 1; c <= 3; c++) cyc(1'b1, 1'b0, 1'b0);
        chk("s6_pre_ovld",  a_out_valid, 1);
        chk("s6_pre_count", a_out_count, 1);
        chk("s6_pre_busy",  a_busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("s6_rst_busy",   a_busy, 0);
        chk("s6_rst_dec_en", a_dec_en, 0);
        chk("s6_rst_phase",  a_phase, 0);
        chk("s6_rst_count",  a_out_count, 0);
        chk("s6_rst_ovld",   a_out_valid, 0);
        chk("s6_rst_done",   a_done, 0);
        chk("s6_rst_busy3",  b_busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            cyc(1'b0, 1'b0, 1'b0);
            chk("s6_post_done", a_done, 0);
            chk("s6_post_busy", a_busy, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
